r5p_htif: RTL and testbench

- Synthesizable HTIF (host-target interface) peripheral on the LSU-side TCB bus, downstream of the core's load/store port, in parallel with the memory model.
- Implements the tohost/fromhost 64-bit mailbox in 32-bit halves and decodes tohost commands: exit (halt with exit code) and console putchar.
- Buffers console characters in a small FIFO and exposes halt/pass/timeout status, replacing the ad-hoc tohost snooping in conformance benches.

---
 rtl/r5p_htif_pkg.sv | 38 +++
 rtl/r5p_htif_fifo.sv | 57 +++++
 rtl/r5p_htif.sv | 190 +++++++++++++++++++
 tb/tb_r5p_htif.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r5p_htif_pkg.sv
// Shared types and constants for the r5p HTIF mailbox peripheral.
package r5p_htif_pkg;

    // Mailbox FSM: IDLE waits for a tohost write, DECODE inspects the command,
    // PUTC waits for console FIFO space, ACK posts the fromhost reply, HALT is terminal.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        PUTC   = 3'd2,
        ACK    = 3'd3,
        HALT   = 3'd4
    } htif_state_t;

    localparam logic [7:0] HTIF_DEV_SYS  = 8'd0;
    localparam logic [7:0] HTIF_DEV_CON  = 8'd1;
    localparam logic [7:0] HTIF_CMD_PUTC = 8'd1;

    // The 64-bit tohost word viewed as an HTIF command.
    typedef struct packed {
        logic [7:0]  dev;
        logic [7:0]  cmd;
        logic [47:0] payload;
    } htif_cmd_t;

    // Merge a bus write into a 32-bit register, one byte lane per enable bit.
    function automatic logic [31:0] merge_ben(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  ben
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = ben[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/r5p_htif_fifo.sv
// Small synchronous FIFO for console characters. Pointers carry one extra
// wrap bit so full and empty are told apart by comparing the MSBs.
module r5p_htif_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdat,
    input  logic             pop,
    output logic [WIDTH-1:0] rdat,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdat  = mem_q[rptr_q[AW-1:0]];

    // Next pointers and storage; a push into a full FIFO or a pop from an empty one is dropped.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (push && !full) begin
            mem_d[wptr_q[AW-1:0]] = wdat;
            wptr_d = wptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // State registers; reset discards any queued characters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/r5p_htif.sv
// HTIF tohost/fromhost mailbox on the LSU-side TCB bus with exit and
// console-putchar decoding, a console FIFO and a run timeout.
//
// Bus handshake: a transfer happens on a rising edge where tcb_vld and tcb_rdy
// are both high; tcb_rdy never depends on anything but state, address and wen,
// and read data appears on tcb_rdt in the cycle after the read transfer.
module r5p_htif
    import r5p_htif_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter logic [31:0] TOHOST     = 32'h8000_1000,
    parameter logic [31:0] FROMHOST   = 32'h8000_1040,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tcb_vld,
    output logic              tcb_rdy,
    input  logic              tcb_wen,
    input  logic [XLEN-1:0]   tcb_adr,
    input  logic [XLEN/8-1:0] tcb_ben,
    input  logic [XLEN-1:0]   tcb_wdt,
    output logic [XLEN-1:0]   tcb_rdt,
    output logic              con_vld,
    input  logic              con_rdy,
    output logic [7:0]        con_dat,
    output logic              halt,
    output logic              pass,
    output logic [30:0]       exit_code,
    output logic              timeout,
    output logic [2:0]        dbg_state
);

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    htif_state_t state_q, state_d;
    logic [31:0] toh_l_q, toh_l_d, toh_h_q, toh_h_d;
    logic [31:0] frh_l_q, frh_l_d, frh_h_q, frh_h_d;
    logic [31:0] rdt_q, rdt_d, rd_val;
    logic        halt_q, halt_d, pass_q, pass_d, timeout_q, timeout_d;
    logic [30:0] exit_code_q, exit_code_d;
    logic [31:0] cnt_q, cnt_d;

    logic        sel_toh_l, sel_toh_h, sel_frh_l, sel_frh_h;
    logic        trn, wr, busy;
    logic        fifo_push, fifo_full, fifo_empty;
    htif_cmd_t   cmd_w;
    logic        unused_payload;

    assign sel_toh_l = (tcb_adr == TOHOST);
    assign sel_toh_h = (tcb_adr == TOHOST + 32'd4);
    assign sel_frh_l = (tcb_adr == FROMHOST);
    assign sel_frh_h = (tcb_adr == FROMHOST + 32'd4);

    // A command is in flight; tohost is locked against software until it retires.
    // HALT is excluded so software may keep writing tohost after exit.
    assign busy    = (state_q == DECODE) || (state_q == PUTC) || (state_q == ACK);
    assign tcb_rdy = !(busy && tcb_wen && (sel_toh_l || sel_toh_h));
    assign trn     = tcb_vld && tcb_rdy;
    assign wr      = trn && tcb_wen;

    assign cmd_w          = htif_cmd_t'({toh_h_q, toh_l_q});
    assign unused_payload = ^cmd_w.payload[47:32];

    assign tcb_rdt   = rdt_q;
    assign halt      = halt_q;
    assign pass      = pass_q;
    assign exit_code = exit_code_q;
    assign timeout   = timeout_q;
    assign con_vld   = !fifo_empty;
    assign dbg_state = state_q;

    r5p_htif_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdat  (cmd_w.payload[7:0]),
        .pop   (con_vld && con_rdy),
        .rdat  (con_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        rd_val = 32'h0;
        if (sel_toh_l) rd_val = toh_l_q;
        if (sel_toh_h) rd_val = toh_h_q;
        if (sel_frh_l) rd_val = frh_l_q;
        if (sel_frh_h) rd_val = frh_h_q;
    end

    // Bus register writes, command FSM and timeout counter; FSM updates are
    // applied after bus writes so ACK overrides a same-cycle fromhost write.
    always_comb begin
        toh_l_d     = toh_l_q;
        toh_h_d     = toh_h_q;
        frh_l_d     = frh_l_q;
        frh_h_d     = frh_h_q;
        rdt_d       = rdt_q;
        state_d     = state_q;
        halt_d      = halt_q;
        pass_d      = pass_q;
        exit_code_d = exit_code_q;
        fifo_push   = 1'b0;

        if (wr && sel_toh_l) toh_l_d = merge_ben(toh_l_q, tcb_wdt, tcb_ben);
        if (wr && sel_toh_h) toh_h_d = merge_ben(toh_h_q, tcb_wdt, tcb_ben);
        if (wr && sel_frh_l) frh_l_d = merge_ben(frh_l_q, tcb_wdt, tcb_ben);
        if (wr && sel_frh_h) frh_h_d = merge_ben(frh_h_q, tcb_wdt, tcb_ben);
        if (trn && !tcb_wen) rdt_d = rd_val;

        case (state_q)
            IDLE: begin
                if (wr && sel_toh_l && (toh_l_d != 32'h0)) state_d = DECODE;
            end
            DECODE: begin
                if ((cmd_w.dev == HTIF_DEV_SYS) && cmd_w.payload[0]) begin
                    state_d     = HALT;
                    halt_d      = 1'b1;
                    exit_code_d = cmd_w.payload[31:1];
                    pass_d      = (cmd_w.payload[31:1] == 31'h0);
                end else if ((cmd_w.dev == HTIF_DEV_CON) && (cmd_w.cmd == HTIF_CMD_PUTC)) begin
                    state_d = PUTC;
                end else begin
                    toh_l_d = 32'h0;
                    toh_h_d = 32'h0;
                    state_d = IDLE;
                end
            end
            PUTC: begin
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                toh_l_d = 32'h0;
                toh_h_d = 32'h0;
                frh_h_d = {cmd_w.dev, cmd_w.cmd, 16'h0};
                frh_l_d = 32'h1;
                state_d = IDLE;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cnt_d = cnt_q;
        if ((TIMEOUT_W != 32'h0) && !halt_q && (cnt_q != TIMEOUT_W)) cnt_d = cnt_q + 32'd1;
        timeout_d = (TIMEOUT_W != 32'h0) && (cnt_d == TIMEOUT_W);
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            toh_l_q     <= 32'h0;
            toh_h_q     <= 32'h0;
            frh_l_q     <= 32'h0;
            frh_h_q     <= 32'h0;
            rdt_q       <= 32'h0;
            halt_q      <= 1'b0;
            pass_q      <= 1'b0;
            exit_code_q <= 31'h0;
            timeout_q   <= 1'b0;
            cnt_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            toh_l_q     <= toh_l_d;
            toh_h_q     <= toh_h_d;
            frh_l_q     <= frh_l_d;
            frh_h_q     <= frh_h_d;
            rdt_q       <= rdt_d;
            halt_q      <= halt_d;
            pass_q      <= pass_d;
            exit_code_q <= exit_code_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_r5p_htif.sv
// Self-checking bench for r5p_htif: mailbox access, exit/putchar decoding,
// console ordering through a character scoreboard, timeout and mid-run reset.
module tb_r5p_htif;
    import r5p_htif_pkg::*;

    localparam logic [31:0] TOH_L_A = 32'h8000_1000;
    localparam logic [31:0] TOH_H_A = 32'h8000_1004;
    localparam logic [31:0] FRH_L_A = 32'h8000_1040;
    localparam logic [31:0] FRH_H_A = 32'h8000_1044;
    localparam logic [31:0] PUTC_H  = 32'h0101_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tcb_vld = 1'b0;
    logic        tcb_rdy;
    logic        tcb_wen = 1'b0;
    logic [31:0] tcb_adr = '0;
    logic [3:0]  tcb_ben = '0;
    logic [31:0] tcb_wdt = '0;
    logic [31:0] tcb_rdt;
    logic        con_vld;
    logic        con_rdy = 1'b0;
    logic [7:0]  con_dat;
    logic        halt;
    logic        pass;
    logic [30:0] exit_code;
    logic        timeout;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [7:0] exp_q[$];

    r5p_htif dut (
        .clk       (clk),
        .rst       (rst),
        .tcb_vld   (tcb_vld),
        .tcb_rdy   (tcb_rdy),
        .tcb_wen   (tcb_wen),
        .tcb_adr   (tcb_adr),
        .tcb_ben   (tcb_ben),
        .tcb_wdt   (tcb_wdt),
        .tcb_rdt   (tcb_rdt),
        .con_vld   (con_vld),
        .con_rdy   (con_rdy),
        .con_dat   (con_dat),
        .halt      (halt),
        .pass      (pass),
        .exit_code (exit_code),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Console scoreboard: a character leaves the DUT on each con_vld & con_rdy edge.
    always @(negedge clk) begin
        #2;
        if (!rst && con_vld && con_rdy) begin
            if (exp_q.size() == 0) begin
                check("con_extra", {24'h0, con_dat}, 32'hffff_ffff);
            end else begin
                check("con_dat", {24'h0, con_dat}, {24'h0, exp_q.pop_front()});
            end
            pops++;
        end
    end

    task automatic do_reset();
        rst     = 1'b1;
        tcb_vld = 1'b0;
        tcb_wen = 1'b0;
        con_rdy = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] adr, input logic [3:0] ben, input logic [31:0] dat);
        int n = 0;
        @(negedge clk);
        tcb_vld = 1'b1; tcb_wen = 1'b1; tcb_adr = adr; tcb_ben = ben; tcb_wdt = dat;
        #1;
        while (!tcb_rdy && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (!tcb_rdy) check("wr_rdy_bound", {31'h0, tcb_rdy}, 32'h1);
        @(posedge clk); #1;
        tcb_vld = 1'b0; tcb_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] adr, output logic [31:0] dat);
        int n = 0;
        @(negedge clk);
        tcb_vld = 1'b1; tcb_wen = 1'b0; tcb_adr = adr; tcb_ben = 4'hf;
        #1;
        while (!tcb_rdy && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (!tcb_rdy) check("rd_rdy_bound", {31'h0, tcb_rdy}, 32'h1);
        @(posedge clk); #1;
        tcb_vld = 1'b0;
        @(negedge clk);
        dat = tcb_rdt;
    endtask

    task automatic read_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(adr, d);
        check(tag, d, exp);
    endtask

    task automatic putchar(input logic [7:0] ch, input bit expect_out);
        bus_write(TOH_H_A, 4'hf, PUTC_H);
        bus_write(TOH_L_A, 4'hf, {24'h0, ch});
        if (expect_out) exp_q.push_back(ch);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st);
        int n = 0;
        while (dbg_state !== st && n < 500) begin
            @(posedge clk); #1; n++;
        end
        check(tag, {29'h0, dbg_state}, {29'h0, st});
    endtask

    // Watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int n;
        int pops0;

        // ---- reset values and timeout ----
        do_reset();
        #1;
        check("rst_rdy", {31'h0, tcb_rdy}, 32'h1);
        check("rst_rdt", tcb_rdt, 32'h0);
        check("rst_con_vld", {31'h0, con_vld}, 32'h0);
        check("rst_halt", {31'h0, halt}, 32'h0);
        check("rst_pass", {31'h0, pass}, 32'h0);
        check("rst_exit", {1'b0, exit_code}, 32'h0);
        check("rst_timeout", {31'h0, timeout}, 32'h0);
        check("rst_state", {29'h0, dbg_state}, {29'h0, IDLE});
        repeat (9999) @(posedge clk);
        #1;
        check("timeout_9999", {31'h0, timeout}, 32'h0);
        @(posedge clk); #1;
        check("timeout_10000", {31'h0, timeout}, 32'h1);
        repeat (5) @(posedge clk); #1;
        check("timeout_sticky", {31'h0, timeout}, 32'h1);

        // ---- mailbox reset contents ----
        do_reset();
        read_check("rst_toh_l", TOH_L_A, 32'h0);
        read_check("rst_toh_h", TOH_H_A, 32'h0);
        read_check("rst_frh_l", FRH_L_A, 32'h0);
        read_check("rst_frh_h", FRH_H_A, 32'h0);

        // ---- single putchar ----
        con_rdy = 1'b1;
        pops0 = pops;
        putchar(8'h41, 1'b1);
        wait_state("putc1_idle", IDLE);
        repeat (4) @(posedge clk); #1;
        check("putc1_pops", pops - pops0, 32'd1);
        check("putc1_sb", exp_q.size(), 32'd0);
        read_check("putc1_toh_l", TOH_L_A, 32'h0);
        read_check("putc1_toh_h", TOH_H_A, 32'h0);
        read_check("putc1_frh_h", FRH_H_A, 32'h0101_0000);
        read_check("putc1_frh_l", FRH_L_A, 32'h1);

        // ---- unknown device: command discarded, no reply ----
        bus_write(FRH_L_A, 4'hf, 32'h0);
        bus_write(TOH_H_A, 4'hf, 32'h0200_0000);
        bus_write(TOH_L_A, 4'hf, 32'h5);
        wait_state("bad_idle", IDLE);
        read_check("bad_toh_l", TOH_L_A, 32'h0);
        read_check("bad_toh_h", TOH_H_A, 32'h0);
        read_check("bad_frh_l", FRH_L_A, 32'h0);
        check("bad_halt", {31'h0, halt}, 32'h0);

        // ---- five putchars into a depth-4 FIFO with the sink stalled ----
        con_rdy = 1'b0;
        for (int i = 0; i < 5; i++) putchar(8'h61 + 8'(i), 1'b1);
        repeat (3) @(posedge clk); #1;
        check("stall_state", {29'h0, dbg_state}, {29'h0, PUTC});
        check("stall_con_vld", {31'h0, con_vld}, 32'h1);
        check("stall_head", {24'h0, con_dat}, 32'h61);
        @(negedge clk);
        tcb_vld = 1'b1; tcb_wen = 1'b1; tcb_adr = TOH_L_A; tcb_ben = 4'hf; tcb_wdt = 32'h99;
        #1;
        check("stall_toh_rdy", {31'h0, tcb_rdy}, 32'h0);
        tcb_vld = 1'b0; tcb_wen = 1'b0;
        @(negedge clk);
        tcb_vld = 1'b1; tcb_wen = 1'b0; tcb_adr = FRH_L_A;
        #1;
        check("stall_frh_rdy", {31'h0, tcb_rdy}, 32'h1);
        @(posedge clk); #1;
        tcb_vld = 1'b0;
        @(negedge clk);
        check("stall_frh_rdt", tcb_rdt, 32'h1);
        con_rdy = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); n++;
        end
        check("drain_sb", exp_q.size(), 32'd0);
        wait_state("drain_idle", IDLE);
        repeat (3) @(posedge clk); #1;
        check("drain_con_vld", {31'h0, con_vld}, 32'h0);

        // ---- byte-enable write and unmapped access ----
        bus_write(FRH_L_A, 4'hf, 32'h1234_5678);
        bus_write(FRH_L_A, 4'b0001, 32'hffff_ff55);
        read_check("ben_frh_l", FRH_L_A, 32'h1234_5655);
        bus_write(32'h8000_2000, 4'hf, 32'hdead_beef);
        read_check("unmapped", 32'h8000_2000, 32'h0);

        // ---- reset while in PUTC with two characters queued ----
        con_rdy = 1'b0;
        putchar(8'h31, 1'b0);
        putchar(8'h32, 1'b0);
        putchar(8'h33, 1'b0);
        @(posedge clk); #1;
        check("mid_state_putc", {29'h0, dbg_state}, {29'h0, PUTC});
        check("mid_con_vld_pre", {31'h0, con_vld}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_con_vld", {31'h0, con_vld}, 32'h0);
        check("mid_state", {29'h0, dbg_state}, {29'h0, IDLE});
        check("mid_rdt", tcb_rdt, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        read_check("mid_toh_l", TOH_L_A, 32'h0);
        read_check("mid_toh_h", TOH_H_A, 32'h0);
        read_check("mid_frh_l", FRH_L_A, 32'h0);
        read_check("mid_frh_h", FRH_H_A, 32'h0);
        check("mid_con_vld_after", {31'h0, con_vld}, 32'h0);

        // ---- exit with code 0 ----
        do_reset();
        bus_write(TOH_L_A, 4'hf, 32'h1);
        check("exit0_halt_early", {31'h0, halt}, 32'h0);
        @(posedge clk); #1;
        check("exit0_halt", {31'h0, halt}, 32'h1);
        check("exit0_pass", {31'h0, pass}, 32'h1);
        check("exit0_code", {1'b0, exit_code}, 32'h0);
        check("exit0_state", {29'h0, dbg_state}, {29'h0, HALT});
        read_check("exit0_toh_l", TOH_L_A, 32'h1);

        // ---- exit with code 3, later tohost write not decoded ----
        do_reset();
        bus_write(TOH_L_A, 4'hf, 32'h7);
        @(posedge clk); #1;
        check("exit3_halt", {31'h0, halt}, 32'h1);
        check("exit3_pass", {31'h0, pass}, 32'h0);
        check("exit3_code", {1'b0, exit_code}, 32'h3);
        bus_write(TOH_L_A, 4'hf, 32'h1);
        repeat (3) @(posedge clk); #1;
        check("exit3_code_kept", {1'b0, exit_code}, 32'h3);
        check("exit3_pass_kept", {31'h0, pass}, 32'h0);
        check("exit3_state", {29'h0, dbg_state}, {29'h0, HALT});
        read_check("exit3_toh_l", TOH_L_A, 32'h1);

        check("final_sb", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
